// File: rtl/wb_arbiter.sv
// Writeback arbiter: buffers ALU and load results in per-source FIFOs and
// drains them round-robin into a single register-file write port.
module wb_arbiter #(
  parameter int DEPTH = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        alu_valid,
  input  logic [4:0]  alu_rd,
  input  logic [31:0] alu_data,
  output logic        alu_ready,
  input  logic        mem_valid,
  input  logic [4:0]  mem_rd,
  input  logic [31:0] mem_data,
  output logic        mem_ready,
  output logic        rf_wen,
  output logic [4:0]  rf_wa,
  output logic [31:0] rf_wd,
  output logic [31:0] pending_mask,
  output logic        busy
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

  typedef enum logic {GRANT_ALU, GRANT_MEM} grant_t;

  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] data;
  } entry_t;

  entry_t alu_q [DEPTH];
  entry_t mem_q [DEPTH];

  logic [PTR_W-1:0] alu_wr_ptr, alu_rd_ptr;
  logic [PTR_W-1:0] mem_wr_ptr, mem_rd_ptr;
  logic [CNT_W-1:0] alu_count, mem_count;

  grant_t last_grant, next_grant;
  logic   grant_alu, grant_mem;
  logic   alu_push, mem_push;

  // Ready depends only on registered counts, so a full queue stays
  // not-ready even on a cycle where it is being drained.
  assign alu_ready = (alu_count != FULL);
  assign mem_ready = (mem_count != FULL);

  // Writes to x0 complete the handshake but are dropped here.
  assign alu_push = alu_valid && alu_ready && (alu_rd != 5'd0);
  assign mem_push = mem_valid && mem_ready && (mem_rd != 5'd0);

  always_comb begin
    grant_alu  = 1'b0;
    grant_mem  = 1'b0;
    next_grant = last_grant;
    if ((alu_count != '0) && ((mem_count == '0) || (last_grant == GRANT_MEM))) begin
      grant_alu  = 1'b1;
      next_grant = GRANT_ALU;
    end else if (mem_count != '0) begin
      grant_mem  = 1'b1;
      next_grant = GRANT_MEM;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      alu_wr_ptr <= '0;
      alu_rd_ptr <= '0;
      alu_count  <= '0;
    end else begin
      if (alu_push)
        alu_wr_ptr <= alu_wr_ptr + PTR_W'(1);
      if (grant_alu)
        alu_rd_ptr <= alu_rd_ptr + PTR_W'(1);
      case ({alu_push, grant_alu})
        2'b10:   alu_count <= alu_count + CNT_W'(1);
        2'b01:   alu_count <= alu_count - CNT_W'(1);
        default: alu_count <= alu_count;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      mem_wr_ptr <= '0;
      mem_rd_ptr <= '0;
      mem_count  <= '0;
    end else begin
      if (mem_push)
        mem_wr_ptr <= mem_wr_ptr + PTR_W'(1);
      if (grant_mem)
        mem_rd_ptr <= mem_rd_ptr + PTR_W'(1);
      case ({mem_push, grant_mem})
        2'b10:   mem_count <= mem_count + CNT_W'(1);
        2'b01:   mem_count <= mem_count - CNT_W'(1);
        default: mem_count <= mem_count;
      endcase
    end
  end

  // Queue storage needs no reset; validity is tracked by the counts.
  always_ff @(posedge clock) begin
    if (alu_push)
      alu_q[alu_wr_ptr] <= '{rd: alu_rd, data: alu_data};
    if (mem_push)
      mem_q[mem_wr_ptr] <= '{rd: mem_rd, data: mem_data};
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rf_wen     <= 1'b0;
      rf_wa      <= 5'd0;
      rf_wd      <= 32'd0;
      last_grant <= GRANT_MEM;
    end else begin
      rf_wen     <= grant_alu || grant_mem;
      last_grant <= next_grant;
      if (grant_alu) begin
        rf_wa <= alu_q[alu_rd_ptr].rd;
        rf_wd <= alu_q[alu_rd_ptr].data;
      end else if (grant_mem) begin
        rf_wa <= mem_q[mem_rd_ptr].rd;
        rf_wd <= mem_q[mem_rd_ptr].data;
      end
    end
  end

  // Walk the live window of each queue starting at its read pointer.
  always_comb begin
    pending_mask = '0;
    for (int k = 0; k < DEPTH; k++) begin
      if (CNT_W'(k) < alu_count)
        pending_mask[alu_q[alu_rd_ptr + PTR_W'(k)].rd] = 1'b1;
      if (CNT_W'(k) < mem_count)
        pending_mask[mem_q[mem_rd_ptr + PTR_W'(k)].rd] = 1'b1;
    end
    if (rf_wen)
      pending_mask[rf_wa] = 1'b1;
    pending_mask[0] = 1'b0;
  end

  assign busy = (alu_count != '0) || (mem_count != '0) || rf_wen;

endmodule
